matrix_result_streamer: RTL

Downstream stage of the matrix calculator. It captures the 25-element, 16-bit result bus and its packed dimension on the calculator's `done`/`error` pulse. It then emits the valid elements one per handshake, in row-major order, with row/column tags, to the display/UART formatter. It decouples the single-cycle `done` pulse from a slow consumer and flags results that are lost while a stream is in progress.

---
 rtl/matrix_result_streamer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/matrix_result_streamer.sv
// Captures a matrix result from the calculator on its done/error pulse and
// streams the valid elements in row-major order with row/column tags.
module matrix_result_streamer #(
    parameter int ELEM_W    = 16,
    parameter int MAX_ELEMS = 25
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          res_valid,
    input  logic                          res_error,
    input  logic [ELEM_W*MAX_ELEMS-1:0]   result_data,
    input  logic [5:0]                    result_dim,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ELEM_W-1:0]             out_data,
    output logic [2:0]                    out_row,
    output logic [2:0]                    out_col,
    output logic                          out_last_col,
    output logic                          out_last,
    output logic                          busy,
    output logic                          err_pulse,
    output logic                          overrun
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]                          state;
    logic [MAX_ELEMS-1:0][ELEM_W-1:0]    cap_data;
    logic [2:0]                          cap_rows;
    logic [2:0]                          cap_cols;

    logic [2:0] dim_rows;
    logic [2:0] dim_cols;
    logic [5:0] dim_area;
    logic       dim_bad;

    logic [2:0] next_row;
    logic [2:0] next_col;
    logic [4:0] next_idx;

    // Dimension legality of the incoming result.
    assign dim_rows = result_dim[5:3];
    assign dim_cols = result_dim[2:0];
    assign dim_area = {3'b000, dim_rows} * {3'b000, dim_cols};
    assign dim_bad  = (dim_rows == 3'd0) || (dim_cols == 3'd0) ||
                      (dim_rows > 3'd5)  || (dim_cols > 3'd5)  ||
                      (dim_area > 6'(MAX_ELEMS));

    // Position of the element presented after the current one is accepted.
    // NOTE: every output of this block gets a default first, so a path that
    // skips an assignment cannot infer a latch.
    always_comb begin
        next_row = out_row;
        next_col = out_col + 3'd1;
        if (out_last_col) begin
            next_row = out_row + 3'd1;
            next_col = 3'd0;
        end
        next_idx = {2'b00, next_row} * {2'b00, cap_cols} + {2'b00, next_col};
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            // NOTE: the capture buffer is flop-based and explicitly cleared so
            // no stale result survives a reset.
            cap_data     <= '0;
            cap_rows     <= 3'd0;
            cap_cols     <= 3'd0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_row      <= 3'd0;
            out_col      <= 3'd0;
            out_last_col <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            err_pulse    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (res_valid) begin
                        if (res_error || dim_bad) begin
                            err_pulse <= 1'b1;
                        end else begin
                            cap_data     <= result_data;
                            cap_rows     <= dim_rows;
                            cap_cols     <= dim_cols;
                            overrun      <= 1'b0;
                            state        <= ST_STREAM;
                            busy         <= 1'b1;
                            out_valid    <= 1'b1;
                            out_data     <= result_data[ELEM_W-1:0];
                            out_row      <= 3'd0;
                            out_col      <= 3'd0;
                            out_last_col <= (dim_cols == 3'd1);
                            out_last     <= (dim_rows == 3'd1) && (dim_cols == 3'd1);
                        end
                    end
                end
                ST_STREAM: begin
                    // A result landing mid-stream (even on the final beat) is lost.
                    if (res_valid) begin
                        overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        if (out_last) begin
                            state        <= ST_IDLE;
                            busy         <= 1'b0;
                            out_valid    <= 1'b0;
                            out_data     <= '0;
                            out_row      <= 3'd0;
                            out_col      <= 3'd0;
                            out_last_col <= 1'b0;
                            out_last     <= 1'b0;
                        end else begin
                            out_data     <= cap_data[next_idx];
                            out_row      <= next_row;
                            out_col      <= next_col;
                            out_last_col <= (next_col == cap_cols - 3'd1);
                            out_last     <= (next_row == cap_rows - 3'd1) &&
                                            (next_col == cap_cols - 3'd1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
